// File: rtl/mips_trace_tx.sv
// mips_trace_tx: trace transmitter for the single-cycle MIPS core.
// Captures {pc_in, result_in} into a DEPTH-entry FIFO whenever cap_en is high.
// Each queued record is sent as a framed byte stream on a valid/ready port:
//   A5, PC[31:24..7:0], RES[31:24..7:0]  (plus an XOR checksum byte when enabled).
// Records arriving while the FIFO is full are dropped and counted.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   cap_en              capture request this cycle
//   pc_in, result_in    core PC and ALU result
//   out_data/out_valid  stream byte and its qualifier (registered)
//   out_ready           sink accept
//   overflow, drop_cnt  sticky drop flag and saturating drop count
//   busy                FIFO non-empty or frame in progress
//
// Optional feature: define TRACE_CHECKSUM_EN to append a CHK byte holding the
// XOR of the 8 payload bytes (10-byte frames).
module mips_trace_tx #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cap_en,
    input  logic [31:0]      pc_in,
    input  logic [31:0]      result_in,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overflow,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             busy
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SYNC = 3'd1,
        ST_PC   = 3'd2,
`ifdef TRACE_CHECKSUM_EN
        ST_RES  = 3'd3,
        ST_CHK  = 3'd4
`else
        ST_RES  = 3'd3
`endif
    } state_t;

    // Big-endian byte pick from a 32-bit word.
    function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

`ifdef TRACE_CHECKSUM_EN
    // XOR of the 8 payload bytes of a record.
    function automatic logic [7:0] payload_xor(input logic [63:0] rec);
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < 8; i++) begin
            x = x ^ rec[i*8 +: 8];
        end
        return x;
    endfunction
`endif

    // Byte presented on the stream for a given serializer position.
    function automatic logic [7:0] frame_byte(input state_t st, input logic [1:0] idx,
                                              input logic [63:0] rec);
        logic [7:0] b;
        case (st)
            ST_SYNC: b = 8'hA5;
            ST_PC:   b = word_byte(rec[63:32], idx);
            ST_RES:  b = word_byte(rec[31:0], idx);
`ifdef TRACE_CHECKSUM_EN
            ST_CHK:  b = payload_xor(rec);
`endif
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    logic [63:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    state_t           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [63:0]      hold_q, hold_d;
    logic [7:0]       out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic             busy_q, busy_d;

    logic hs_s, full_s, empty_s, push_s, drop_s, pop_s, frame_done_s;

    // Next-state logic for FIFO bookkeeping, serializer and registered outputs.
    always_comb begin
        hs_s         = out_valid_q && out_ready;
        full_s       = (occ_q == FULL_OCC);
        empty_s      = (occ_q == {OCC_W{1'b0}});
        push_s       = cap_en && !full_s;
        drop_s       = cap_en && full_s;
        pop_s        = 1'b0;
        frame_done_s = 1'b0;
        state_d      = state_q;
        idx_d        = idx_q;
        hold_d       = hold_q;

        case (state_q)
            // Idle behaves like a just-finished frame: start one if data waits.
            ST_IDLE: frame_done_s = 1'b1;
            ST_SYNC: begin
                if (hs_s) begin
                    state_d = ST_PC;
                    idx_d   = 2'd0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_PC: begin
                if (hs_s && (idx_q == 2'd3)) begin
                    state_d = ST_RES;
                    idx_d   = 2'd0;
                end else if (hs_s) begin
                    idx_d = idx_q + 2'd1;
                end else begin
                    idx_d = idx_q;
                end
            end
            ST_RES: begin
                if (hs_s && (idx_q == 2'd3)) begin
`ifdef TRACE_CHECKSUM_EN
                    state_d = ST_CHK;
                    idx_d   = 2'd0;
`else
                    frame_done_s = 1'b1;
`endif
                end else if (hs_s) begin
                    idx_d = idx_q + 2'd1;
                end else begin
                    idx_d = idx_q;
                end
            end
`ifdef TRACE_CHECKSUM_EN
            ST_CHK: begin
                if (hs_s) begin
                    frame_done_s = 1'b1;
                end else begin
                    frame_done_s = 1'b0;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        // End of frame (or idle): pop the next record on the same edge, no bubble.
        if (frame_done_s) begin
            idx_d = 2'd0;
            if (!empty_s) begin
                pop_s   = 1'b1;
                hold_d  = mem_q[rd_ptr_q];
                state_d = ST_SYNC;
            end else begin
                state_d = ST_IDLE;
            end
        end else begin
            pop_s = 1'b0;
        end

        wr_ptr_d = push_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase

        // A drop is decided on pre-edge occupancy, even if a pop happens too.
        overflow_d = overflow_q | drop_s;
        if (drop_s && (drop_cnt_q != {CNT_W{1'b1}})) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end else begin
            drop_cnt_d = drop_cnt_q;
        end

        // Outputs are computed from next state so they leave a flop directly.
        out_valid_d = (state_d != ST_IDLE);
        out_data_d  = out_valid_d ? frame_byte(state_d, idx_d, hold_d) : 8'h00;
        busy_d      = (occ_d != {OCC_W{1'b0}}) || (state_d != ST_IDLE);
    end

    // Record storage; no reset needed because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= {pc_in, result_in};
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= {PTR_W{1'b0}};
            rd_ptr_q    <= {PTR_W{1'b0}};
            occ_q       <= {OCC_W{1'b0}};
            state_q     <= ST_IDLE;
            idx_q       <= 2'd0;
            hold_q      <= 64'h0;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            drop_cnt_q  <= {CNT_W{1'b0}};
            busy_q      <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            state_q     <= state_d;
            idx_q       <= idx_d;
            hold_q      <= hold_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
            drop_cnt_q  <= drop_cnt_d;
            busy_q      <= busy_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mips_trace_tx.sv
// Bench for mips_trace_tx: a record/byte-queue model checked every cycle,
// plus hand-computed expectations for latency, frame contents, overflow,
// back-to-back streaming and reset in mid-frame.
module tb_mips_trace_tx;
    localparam int DEPTH = 8;
    localparam int CNT_W = 8;
`ifdef TRACE_CHECKSUM_EN
    localparam int FRAME_LEN = 10;
`else
    localparam int FRAME_LEN = 9;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cap_en = 1'b0;
    logic [31:0]      pc_in = 32'h0;
    logic [31:0]      result_in = 32'h0;
    logic             out_ready = 1'b0;
    logic [7:0]       out_data;
    logic             out_valid;
    logic             overflow;
    logic [CNT_W-1:0] drop_cnt;
    logic             busy;

    int checks = 0;
    int errors = 0;

    mips_trace_tx #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .cap_en(cap_en), .pc_in(pc_in),
        .result_in(result_in), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .overflow(overflow), .drop_cnt(drop_cnt),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // m_fifo: records captured but not yet being sent.
    // m_frame: bytes of the frame in flight still to be accepted (front = on the wire).
    logic [63:0] m_fifo[$];
    logic [7:0]  m_frame[$];
    bit          m_overflow = 1'b0;
    int          m_drop = 0;
    logic [7:0]  rx_log[$];

    function automatic void load_frame(input logic [63:0] rec);
        logic [7:0] x;
        x = 8'h00;
        m_frame.delete();
        m_frame.push_back(8'hA5);
        for (int i = 7; i >= 0; i--) begin
            m_frame.push_back(rec[i*8 +: 8]);
            x = x ^ rec[i*8 +: 8];
        end
`ifdef TRACE_CHECKSUM_EN
        m_frame.push_back(x);
`endif
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_fifo.delete();
                m_frame.delete();
                m_overflow = 1'b0;
                m_drop = 0;
            end else begin
                bit hs, pop, was_full;
                was_full = (m_fifo.size() >= DEPTH);
                hs  = (m_frame.size() != 0) && out_ready;
                pop = (m_fifo.size() != 0) &&
                      ((m_frame.size() == 0) || (hs && m_frame.size() == 1));
                if (hs) void'(m_frame.pop_front());
                if (pop) load_frame(m_fifo.pop_front());
                if (cap_en) begin
                    if (!was_full) begin
                        m_fifo.push_back({pc_in, result_in});
                    end else begin
                        m_overflow = 1'b1;
                        if (m_drop < (1 << CNT_W) - 1) m_drop++;
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model, and log of accepted bytes.
    initial begin
        forever begin
            @(negedge clk);
            chk("out_valid", 64'(out_valid), 64'(m_frame.size() != 0));
            if (m_frame.size() != 0) chk("out_data", 64'(out_data), 64'(m_frame[0]));
            chk("busy", 64'(busy), 64'((m_fifo.size() != 0) || (m_frame.size() != 0)));
            chk("overflow", 64'(overflow), 64'(m_overflow));
            chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
            if (out_valid === 1'b1 && out_ready === 1'b1) rx_log.push_back(out_data);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_bytes(input int n, input string name);
        int k;
        k = 0;
        while (rx_log.size() < n && k < 2000) begin
            step();
            k++;
        end
        chk(name, 64'(rx_log.size()), 64'(n));
    endtask

    logic [7:0] exp_single [9];
    int run, best;

    initial begin
        exp_single[0] = 8'hA5; exp_single[1] = 8'h00; exp_single[2] = 8'h00;
        exp_single[3] = 8'h00; exp_single[4] = 8'h04; exp_single[5] = 8'h00;
        exp_single[6] = 8'h00; exp_single[7] = 8'h00; exp_single[8] = 8'h0A;

        // Reset state
        repeat (3) step();
        chk("rst_out_data", 64'(out_data), 64'h00);
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_overflow", 64'(overflow), 64'h0);
        chk("rst_drop_cnt", 64'(drop_cnt), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        rst_n = 1'b1;
        repeat (2) step();

        // Single record: latency and frame bytes
        out_ready = 1'b1;
        rx_log.delete();
        pc_in = 32'h0000_0004; result_in = 32'h0000_000A; cap_en = 1'b1;
        step();
        cap_en = 1'b0;
        chk("lat_capture_edge_valid", 64'(out_valid), 64'h0);
        chk("lat_capture_edge_busy", 64'(busy), 64'h1);
        step();
        chk("lat_first_valid", 64'(out_valid), 64'h1);
        chk("lat_first_data", 64'(out_data), 64'hA5);
        wait_bytes(FRAME_LEN, "single_count");
        for (int i = 0; i < 9; i++) chk("single_byte", 64'(rx_log[i]), 64'(exp_single[i]));
        chk("single_busy_after", 64'(busy), 64'h0);
        chk("single_valid_after", 64'(out_valid), 64'h0);

        // Backpressure: ready pattern 1,0,0 repeating
        rx_log.delete();
        out_ready = 1'b0;
        cap_en = 1'b1;
        step();
        cap_en = 1'b0;
        for (int c = 0; c < 3 * FRAME_LEN + 6; c++) begin
            out_ready = (c % 3 == 0);
            step();
        end
        out_ready = 1'b0;
        repeat (3) step();
        chk("bp_count", 64'(rx_log.size()), 64'(FRAME_LEN));
        for (int i = 0; i < 9; i++) chk("bp_byte", 64'(rx_log[i]), 64'(exp_single[i]));

        // Overflow: 12 captures with the sink stalled
        rx_log.delete();
        for (int i = 0; i < 12; i++) begin
            pc_in = 32'(4 * i); result_in = 32'hC000_0000 | 32'(i); cap_en = 1'b1;
            step();
        end
        cap_en = 1'b0;
        // rec0 moves to the holding register one edge after capture, so 8 more fit.
        chk("ovf_flag", 64'(overflow), 64'h1);
        chk("ovf_drop_cnt", 64'(drop_cnt), 64'd3);
        out_ready = 1'b1;
        wait_bytes(9 * FRAME_LEN, "ovf_count");
        for (int r = 0; r < 9; r++) begin
            chk("ovf_sync", 64'(rx_log[r*FRAME_LEN]), 64'hA5);
            chk("ovf_pc", 64'({rx_log[r*FRAME_LEN+1], rx_log[r*FRAME_LEN+2],
                               rx_log[r*FRAME_LEN+3], rx_log[r*FRAME_LEN+4]}), 64'(4 * r));
            chk("ovf_res_lo", 64'(rx_log[r*FRAME_LEN+8]), 64'(r));
        end
        step();
        chk("ovf_busy_after", 64'(busy), 64'h0);
        chk("ovf_drop_held", 64'(drop_cnt), 64'd3);

        // Back-to-back: two consecutive captures stream with no gap
        rx_log.delete();
        pc_in = 32'h1122_3344; result_in = 32'h5566_7788; cap_en = 1'b1;
        step();
        pc_in = 32'hDEAD_BEEF; result_in = 32'h0102_0304;
        step();
        cap_en = 1'b0;
        run = 0; best = 0;
        for (int c = 0; c < 30; c++) begin
            if (out_valid === 1'b1) begin
                run++;
                if (run > best) best = run;
            end else begin
                run = 0;
            end
            step();
        end
        chk("b2b_run", 64'(best), 64'(2 * FRAME_LEN));
        chk("b2b_second_sync", 64'(rx_log[FRAME_LEN]), 64'hA5);
        chk("b2b_second_pc_hi", 64'(rx_log[FRAME_LEN+1]), 64'hDE);

        // Distinct payload pattern (and checksum byte when enabled)
        rx_log.delete();
        pc_in = 32'h1234_5678; result_in = 32'h9ABC_DEF0; cap_en = 1'b1;
        step();
        cap_en = 1'b0;
        wait_bytes(FRAME_LEN, "pat_count");
        chk("pat_pc_b3", 64'(rx_log[1]), 64'h12);
        chk("pat_pc_b0", 64'(rx_log[4]), 64'h78);
        chk("pat_res_b3", 64'(rx_log[5]), 64'h9A);
        chk("pat_res_b0", 64'(rx_log[8]), 64'hF0);
`ifdef TRACE_CHECKSUM_EN
        // 12^34^56^78^9A^BC^DE^F0 = 00
        chk("chk_byte", 64'(rx_log[9]), 64'h00);
`endif

        // Reset in mid-frame with two records queued
        rx_log.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pc_in = 32'h100 + 32'(i); result_in = 32'h200 + 32'(i); cap_en = 1'b1;
            step();
        end
        cap_en = 1'b0;
        out_ready = 1'b1;
        wait_bytes(4, "mid_bytes_before_reset");
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'h0);
        chk("mid_rst_data", 64'(out_data), 64'h00);
        chk("mid_rst_busy", 64'(busy), 64'h0);
        repeat (2) step();
        rst_n = 1'b1;
        repeat (20) step();
        chk("mid_after_valid", 64'(out_valid), 64'h0);
        chk("mid_after_busy", 64'(busy), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
